exec_stage: RTL
===============

Name: exec_stage

Overview:
- Execute stage of the 16-bit pipelined core. It sits directly downstream of the register-read stage and upstream of the memory stage.
- Registers the issued instruction and computes its ALU result. Maintains the architectural carry (C) and zero (Z) flags and evaluates the conditional ops (ADC/ADZ/NDC/NDZ).
- Resolves BEQ/JAL/JLR and produces the EX forwarding value consumed by register read.

Parameters:
- XLEN, 16, datapath and PC width
- REG_IDX_W, 3, register index width
- OP_W, 26, one-hot opcode width
- PC_STEP, 2, return-address increment for JAL/JLR

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- opcode_valid_i  in  1  instruction valid from register read
- opcode_pc_i  in  XLEN  instruction PC
- opcode_instr_i  in  16  raw instruction
- one_hot_i  in  OP_W  one-hot opcode
- operand_val_a_i  in  XLEN  operand A (already forwarded)
- operand_val_b_i  in  XLEN  operand B (already forwarded)
- imm_val_i  in  XLEN  sign-extended immediate
- exec_rd_idx_i  in  REG_IDX_W  destination register
- stall_i  in  1  memory stage busy
- stall_o  out  1  combinational copy of stall_i, driven to upstream
- opcode_valid_o  out  1  valid to memory stage
- opcode_pc_o  out  XLEN  PC passthrough
- opcode_instr_o  out  16  instruction passthrough
- one_hot_o  out  OP_W  opcode passthrough
- result_o  out  XLEN  ALU result, link address, or memory address
- mem_wdata_o  out  XLEN  store data
- rd_idx_o  out  REG_IDX_W  destination register
- wb_en_o  out  1  rd write required downstream
- ex_val_o  out  XLEN  forwarding value, equals result_o
- ex_rd_idx_o  out  REG_IDX_W  forwarding index
- ex_fwd_valid_o  out  1  wb_en_o & ~LW; a load result is not forwardable
- branch_valid_o  out  1  one-cycle redirect pulse
- branch_pc_o  out  XLEN  redirect target
- flag_c_o  out  1  carry flag
- flag_z_o  out  1  zero flag

Behaviour:
- Reset: all outputs, flags and internal state are cleared to 0 asynchronously. A reset mid-instruction drops that instruction.
- Capture cycle: any cycle with stall_i=0. Inputs are registered and outputs update on the next edge (latency 1).
  - If opcode_valid_i=0 or squash_q=1, capture a bubble: valid and wb_en go to 0, flags unchanged.
- stall_i=1: every output register, the flags and squash_q hold. branch_valid_o still drops to 0 after its single cycle.
- Arithmetic:
  - ADD/ADC/ADZ/ADI produce {C,res} = a + (b or imm), 17 bits.
  - NDU/NDC/NDZ produce ~(a & b); C is unchanged.
  - Z = (res == 0) on every executed ALU op.
  - LHI: res = imm.
  - LW/SW: res = b + imm; SW sets mem_wdata_o = a; no flag update.
- Conditional ops: ADC/NDC execute only if C=1; ADZ/NDZ only if Z=1. The flags tested are the registered flags, so back-to-back ops see the previous op's update.
  - Suppressed op: valid stays 1, wb_en_o=0, flags unchanged.
- Branches:
  - BEQ is taken if a == b; target = pc + imm.
  - JAL: res = pc + PC_STEP, wb_en=1, target = pc + imm.
  - JLR: res = pc + PC_STEP, target = b.
  - Taken branch: branch_valid_o=1 and branch_pc_o=target for exactly one cycle; set squash_q.
- Squash: squash_q clears on the next capture cycle, and the input presented in that cycle is dropped (wrong-path instruction).
  - A stall between branch and squash delays the squash without losing it.
  - An invalid input on the squash cycle still consumes the squash.
- Unrecognised or all-zero one-hot with valid=1: treated as a NOP, wb_en=0.

Optional Feature:
- Macro EXEC_PERF_CNT_EN.
- Defined: adds 16-bit saturating counters exec_cnt_o (executed ops), supp_cnt_o (conditionally suppressed ops) and squash_cnt_o (squashed inputs). They update on capture cycles and reset to 0.
- Undefined: ports and logic are absent.

Decomposition:
- One-hot opcode index constants live in the shared def_ex definitions.
- New shared items go into the same package: FLAG_C and FLAG_Z bit positions, and a cond-exec helper function.
- One natural sub-module: exec_alu, a combinational unit taking a, b, imm, one-hot, C and Z, and returning res, carry, zero, exec_en, br_taken and br_target. The top module keeps the pipeline registers, flags and squash.

Test Plan:
- ADD, a=0x2222, b=0x3333 → next cycle result_o=0x5555, wb_en_o=1, C=0, Z=0.
- ADD 0xFFFF+0x0001 → result 0x0000, C=1, Z=1. Following ADC 0x0001+0x0002 executes → 0x0003, C=0, Z=0. A second ADC is suppressed → wb_en_o=0.
- BEQ at pc=0x0110, a=b=0x4444, imm=0x0010 → branch_valid_o pulses once with branch_pc_o=0x0120. The next input (ADI) is squashed → opcode_valid_o=0.
- JAL at pc=0x0104, imm=0x3EFC → result_o=0x0106, wb_en_o=1, branch_pc_o=0x4000.
- LW, b=0x1000, imm=0x0004 → result_o=0x1004, wb_en_o=1, ex_fwd_valid_o=0. Holding stall_i=1 for 3 cycles keeps all outputs frozen.
- rst_ni low during a taken-branch cycle → all outputs 0 immediately. After release no squash is pending and the first valid ADD is executed.

Source files
------------

// File: rtl/def_ex.sv
// rtl/def_ex.sv - shared execute-stage definitions: one-hot opcode indices, flag positions, decode helpers
package def_ex;

    localparam int DEF_XLEN      = 16;
    localparam int DEF_REG_IDX_W = 3;
    localparam int DEF_OP_W      = 26;
    localparam int DEF_PC_STEP   = 2;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    typedef enum int unsigned {
        OP_ADD = 0,
        OP_ADC,
        OP_ADZ,
        OP_ADI,
        OP_NDU,
        OP_NDC,
        OP_NDZ,
        OP_LHI,
        OP_LW,
        OP_SW,
        OP_BEQ,
        OP_JAL,
        OP_JLR
    } op_idx_e;

    localparam int OP_COUNT = 13;

    typedef logic [DEF_OP_W-1:0] one_hot_t;

    function automatic logic is_op(input one_hot_t oh, input op_idx_e idx);
        return oh == (one_hot_t'(1) << idx);
    endfunction

    // Anything that is not exactly one of the defined bits decodes as a NOP.
    function automatic logic op_known(input one_hot_t oh);
        return $onehot(oh) && (oh < (one_hot_t'(1) << OP_COUNT));
    endfunction

    function automatic logic cond_ok(input one_hot_t oh, input logic [1:0] flags);
        if (is_op(oh, OP_ADC) || is_op(oh, OP_NDC))
            return flags[FLAG_C];
        if (is_op(oh, OP_ADZ) || is_op(oh, OP_NDZ))
            return flags[FLAG_Z];
        return 1'b1;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational ALU, condition evaluation and branch resolution
module exec_alu
    import def_ex::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int OP_W    = DEF_OP_W,
    parameter int PC_STEP = DEF_PC_STEP
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] imm,
    input  logic [OP_W-1:0] one_hot,
    input  logic            flag_c,
    input  logic            flag_z,
    output logic [XLEN-1:0] res,
    output logic            carry,
    output logic            zero,
    output logic            exec_en,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target
);

    logic [XLEN:0] sum;
    logic [1:0]    flags;

    always_comb begin
        flags         = '0;
        flags[FLAG_C] = flag_c;
        flags[FLAG_Z] = flag_z;
        sum           = '0;
        res           = '0;
        carry         = flag_c;
        br_taken      = 1'b0;
        br_target     = '0;
        exec_en       = op_known(one_hot) & cond_ok(one_hot, flags);

        if (is_op(one_hot, OP_ADD) || is_op(one_hot, OP_ADC) || is_op(one_hot, OP_ADZ)) begin
            sum   = {1'b0, a} + {1'b0, b};
            res   = sum[XLEN-1:0];
            carry = sum[XLEN];
        end else if (is_op(one_hot, OP_ADI)) begin
            sum   = {1'b0, a} + {1'b0, imm};
            res   = sum[XLEN-1:0];
            carry = sum[XLEN];
        end else if (is_op(one_hot, OP_NDU) || is_op(one_hot, OP_NDC) || is_op(one_hot, OP_NDZ)) begin
            res = ~(a & b);
        end else if (is_op(one_hot, OP_LHI)) begin
            res = imm;
        end else if (is_op(one_hot, OP_LW) || is_op(one_hot, OP_SW)) begin
            res = b + imm;
        end else if (is_op(one_hot, OP_BEQ)) begin
            br_taken  = (a == b);
            br_target = pc + imm;
        end else if (is_op(one_hot, OP_JAL)) begin
            res       = pc + XLEN'(PC_STEP);
            br_taken  = 1'b1;
            br_target = pc + imm;
        end else if (is_op(one_hot, OP_JLR)) begin
            res       = pc + XLEN'(PC_STEP);
            br_taken  = 1'b1;
            br_target = b;
        end

        zero     = (res == '0);
        br_taken = br_taken & exec_en;
    end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: pipeline registers, C/Z flags, branch redirect and squash (optional EXEC_PERF_CNT_EN counters)
module exec_stage
    import def_ex::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int REG_IDX_W = DEF_REG_IDX_W,
    parameter int OP_W      = DEF_OP_W,
    parameter int PC_STEP   = DEF_PC_STEP
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 opcode_valid_i,
    input  logic [XLEN-1:0]      opcode_pc_i,
    input  logic [15:0]          opcode_instr_i,
    input  logic [OP_W-1:0]      one_hot_i,
    input  logic [XLEN-1:0]      operand_val_a_i,
    input  logic [XLEN-1:0]      operand_val_b_i,
    input  logic [XLEN-1:0]      imm_val_i,
    input  logic [REG_IDX_W-1:0] exec_rd_idx_i,
    input  logic                 stall_i,
    output logic                 stall_o,
    output logic                 opcode_valid_o,
    output logic [XLEN-1:0]      opcode_pc_o,
    output logic [15:0]          opcode_instr_o,
    output logic [OP_W-1:0]      one_hot_o,
    output logic [XLEN-1:0]      result_o,
    output logic [XLEN-1:0]      mem_wdata_o,
    output logic [REG_IDX_W-1:0] rd_idx_o,
    output logic                 wb_en_o,
    output logic [XLEN-1:0]      ex_val_o,
    output logic [REG_IDX_W-1:0] ex_rd_idx_o,
    output logic                 ex_fwd_valid_o,
    output logic                 branch_valid_o,
    output logic [XLEN-1:0]      branch_pc_o,
    output logic                 flag_c_o,
    output logic                 flag_z_o
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [15:0]          exec_cnt_o,
    output logic [15:0]          supp_cnt_o,
    output logic [15:0]          squash_cnt_o
`endif
);

    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] alu_br_target;
    logic            alu_carry;
    logic            alu_zero;
    logic            alu_exec_en;
    logic            alu_br_taken;
    logic            squash_q;
    logic            dropped;
    logic            is_add;
    logic            is_nand;
    logic            writes_rd;

    exec_alu #(
        .XLEN    (XLEN),
        .OP_W    (OP_W),
        .PC_STEP (PC_STEP)
    ) u_alu (
        .pc        (opcode_pc_i),
        .a         (operand_val_a_i),
        .b         (operand_val_b_i),
        .imm       (imm_val_i),
        .one_hot   (one_hot_i),
        .flag_c    (flag_c_o),
        .flag_z    (flag_z_o),
        .res       (alu_res),
        .carry     (alu_carry),
        .zero      (alu_zero),
        .exec_en   (alu_exec_en),
        .br_taken  (alu_br_taken),
        .br_target (alu_br_target)
    );

    assign is_add  = is_op(one_hot_i, OP_ADD) | is_op(one_hot_i, OP_ADC)
                   | is_op(one_hot_i, OP_ADZ) | is_op(one_hot_i, OP_ADI);
    assign is_nand = is_op(one_hot_i, OP_NDU) | is_op(one_hot_i, OP_NDC)
                   | is_op(one_hot_i, OP_NDZ);
    assign writes_rd = is_add | is_nand | is_op(one_hot_i, OP_LHI) | is_op(one_hot_i, OP_LW)
                     | is_op(one_hot_i, OP_JAL) | is_op(one_hot_i, OP_JLR);

    // The instruction right behind a taken branch is wrong-path and is dropped.
    assign dropped = ~opcode_valid_i | squash_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_valid_o <= 1'b0;
            opcode_pc_o    <= '0;
            opcode_instr_o <= '0;
            one_hot_o      <= '0;
            result_o       <= '0;
            mem_wdata_o    <= '0;
            rd_idx_o       <= '0;
            wb_en_o        <= 1'b0;
            branch_valid_o <= 1'b0;
            branch_pc_o    <= '0;
            flag_c_o       <= 1'b0;
            flag_z_o       <= 1'b0;
            squash_q       <= 1'b0;
        end else begin
            branch_valid_o <= 1'b0;
            if (!stall_i) begin
                opcode_pc_o    <= opcode_pc_i;
                opcode_instr_o <= opcode_instr_i;
                one_hot_o      <= one_hot_i;
                result_o       <= alu_res;
                mem_wdata_o    <= is_op(one_hot_i, OP_SW) ? operand_val_a_i : '0;
                rd_idx_o       <= exec_rd_idx_i;
                squash_q       <= 1'b0;
                if (dropped) begin
                    opcode_valid_o <= 1'b0;
                    wb_en_o        <= 1'b0;
                end else begin
                    opcode_valid_o <= 1'b1;
                    wb_en_o        <= alu_exec_en & writes_rd;
                    if (alu_exec_en && is_add)
                        flag_c_o <= alu_carry;
                    if (alu_exec_en && (is_add || is_nand))
                        flag_z_o <= alu_zero;
                    if (alu_br_taken) begin
                        branch_valid_o <= 1'b1;
                        branch_pc_o    <= alu_br_target;
                        squash_q       <= 1'b1;
                    end
                end
            end
        end
    end

    assign stall_o        = stall_i;
    assign ex_val_o       = result_o;
    assign ex_rd_idx_o    = rd_idx_o;
    assign ex_fwd_valid_o = wb_en_o & ~is_op(one_hot_o, OP_LW);

`ifdef EXEC_PERF_CNT_EN
    logic cnt_exec;
    logic cnt_supp;
    logic cnt_squash;

    assign cnt_exec   = ~stall_i & ~dropped & alu_exec_en;
    assign cnt_supp   = ~stall_i & ~dropped & op_known(one_hot_i) & ~alu_exec_en;
    assign cnt_squash = ~stall_i & squash_q & opcode_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exec_cnt_o   <= '0;
            supp_cnt_o   <= '0;
            squash_cnt_o <= '0;
        end else begin
            if (cnt_exec && exec_cnt_o != 16'hFFFF)
                exec_cnt_o <= exec_cnt_o + 16'd1;
            if (cnt_supp && supp_cnt_o != 16'hFFFF)
                supp_cnt_o <= supp_cnt_o + 16'd1;
            if (cnt_squash && squash_cnt_o != 16'hFFFF)
                squash_cnt_o <= squash_cnt_o + 16'd1;
        end
    end
`endif

endmodule
